// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: steps the 3-bit decoder select in hold/up/down/bounce at a switch-selected rate,
// with a debounced active-low key that toggles run/pause.
// Ports: CLK clock; RST sync active-high reset; SW[1:0] mode, SW[3:2] speed (P = DIV_MAX >> SW[3:2]);
// KEY async active-low button; SEL registered select; STEP one-cycle pulse with each new SEL; RUN 1=running.
module led_seq_ctrl #(
    parameter int DIV_MAX    = 25_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] SW,
    input  logic       KEY,
    output logic [2:0] SEL,
    output logic       STEP,
    output logic       RUN
);
    localparam int CW = $clog2(DIV_MAX);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    typedef enum logic {UP, DN} dir_t;
    logic          k1, k2, kd, kd_n, run_n, step_n, tick;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   p;
    logic [2:0]    sel_n;
    dir_t          dir, dir_n;
    always_ff @(posedge CLK) begin
        if (RST) begin
            k1   <= 1'b1;
            k2   <= 1'b1;
            kd   <= 1'b1;
            dcnt <= '0;
            cnt  <= '0;
            dir  <= UP;
            SEL  <= 3'd0;
            STEP <= 1'b0;
            RUN  <= 1'b1;
        end else begin
            k1   <= KEY;
            k2   <= k1;
            kd   <= kd_n;
            dcnt <= dcnt_n;
            cnt  <= cnt_n;
            dir  <= dir_n;
            SEL  <= sel_n;
            STEP <= step_n;
            RUN  <= run_n;
        end
    end
    always_comb begin
        kd_n   = kd;
        dcnt_n = '0;
        // the new level is accepted one cycle after the counter has reached DEB_CYCLES
        if (k2 != kd) begin
            if (dcnt == DW'(DEB_CYCLES)) kd_n = k2;
            else dcnt_n = dcnt + DW'(1);
        end
        run_n = (kd && !kd_n) ? !RUN : RUN;
        p     = 32'(DIV_MAX) >> SW[3:2];
        // >= lets a speed-up that strands cnt above the new terminal tick on the next cycle
        tick  = RUN && (32'(cnt) >= p - 32'd1);
        cnt_n = tick ? '0 : (RUN ? cnt + CW'(1) : cnt);
        sel_n  = SEL;
        dir_n  = dir;
        step_n = tick && (SW[1:0] != 2'b00);
        if (tick) begin
            case (SW[1:0])
                2'b01:   sel_n = SEL + 3'd1;
                2'b10:   sel_n = SEL - 3'd1;
                2'b11: begin
                    if (dir == UP) begin
                        sel_n = (SEL == 3'd7) ? 3'd6 : SEL + 3'd1;
                        dir_n = (SEL == 3'd7) ? DN : UP;
                    end else begin
                        sel_n = (SEL == 3'd0) ? 3'd1 : SEL - 3'd1;
                        dir_n = (SEL == 3'd0) ? UP : DN;
                    end
                end
                default: sel_n = SEL;
            endcase
        end
    end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: table-driven directed checks of led_seq_ctrl with DIV_MAX=8, DEB_CYCLES=4.
module tb_led_seq_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] SW  = 4'b0000;
    logic       KEY = 1'b1;
    logic [2:0] SEL;
    logic       STEP, RUN;
    int         n_pass = 0;
    int         n_tot  = 0;

    led_seq_ctrl #(.DIV_MAX(8), .DEB_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .SW(SW), .KEY(KEY), .SEL(SEL), .STEP(STEP), .RUN(RUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic       key;
        int         n;
        logic [2:0] sel;
        logic       step;
        logic       run;
    } vec_t;

    vec_t tv[64];
    int   nv = 0;

    task automatic add(input logic rst, input logic [3:0] sw, input logic key, input int n,
                       input logic [2:0] sel, input logic step, input logic run);
        tv[nv] = '{rst, sw, key, n, sel, step, run};
        nv++;
    endtask

    task automatic chk(input string name, input int idx, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, idx, got, exp, $time);
    endtask

    initial begin
        int n;
        // up, speed 0: a step every 8 edges, wrap 7->0 on the 8th step
        add(1, 4'b0001, 1, 1,  0, 0, 1);
        add(0, 4'b0001, 1, 7,  0, 0, 1);
        add(0, 4'b0001, 1, 1,  1, 1, 1);
        add(0, 4'b0001, 1, 1,  1, 0, 1);
        add(0, 4'b0001, 1, 7,  2, 1, 1);
        add(0, 4'b0001, 1, 40, 7, 1, 1);
        add(0, 4'b0001, 1, 1,  7, 0, 1);
        add(0, 4'b0001, 1, 7,  0, 1, 1);
        // up, speed 2: P=2
        add(1, 4'b1001, 1, 1,  0, 0, 1);
        add(0, 4'b1001, 1, 1,  0, 0, 1);
        add(0, 4'b1001, 1, 1,  1, 1, 1);
        add(0, 4'b1001, 1, 1,  1, 0, 1);
        add(0, 4'b1001, 1, 1,  2, 1, 1);
        // speed 0 -> 3 at cnt=5: immediate step, then every cycle
        add(1, 4'b0001, 1, 1,  0, 0, 1);
        add(0, 4'b0001, 1, 5,  0, 0, 1);
        add(0, 4'b1101, 1, 1,  1, 1, 1);
        add(0, 4'b1101, 1, 1,  2, 1, 1);
        add(0, 4'b1101, 1, 3,  5, 1, 1);
        // down, then hold mid-run, then down again
        add(1, 4'b0010, 1, 1,  0, 0, 1);
        add(0, 4'b0010, 1, 8,  7, 1, 1);
        add(0, 4'b0010, 1, 8,  6, 1, 1);
        add(0, 4'b0000, 1, 8,  6, 0, 1);
        add(0, 4'b0000, 1, 16, 6, 0, 1);
        add(0, 4'b0010, 1, 8,  5, 1, 1);
        // bounce, with an up detour that must not disturb the stored direction
        add(1, 4'b0011, 1, 1,  0, 0, 1);
        add(0, 4'b0011, 1, 56, 7, 1, 1);
        add(0, 4'b0011, 1, 8,  6, 1, 1);
        add(0, 4'b0011, 1, 16, 4, 1, 1);
        add(0, 4'b0001, 1, 8,  5, 1, 1);
        add(0, 4'b0001, 1, 8,  6, 1, 1);
        add(0, 4'b0011, 1, 8,  5, 1, 1);
        add(0, 4'b0011, 1, 40, 0, 1, 1);
        add(0, 4'b0011, 1, 8,  1, 1, 1);
        add(0, 4'b0011, 1, 8,  2, 1, 1);
        // reset mid-run at SEL=5 descending
        add(1, 4'b0011, 1, 1,  0, 0, 1);
        add(0, 4'b0011, 1, 72, 5, 1, 1);
        add(1, 4'b0011, 1, 1,  0, 0, 1);
        add(0, 4'b0011, 1, 7,  0, 0, 1);
        add(0, 4'b0011, 1, 1,  1, 1, 1);
        add(0, 4'b0011, 1, 8,  2, 1, 1);
        // reset while descending must restore dir=up (seen via up to 3, then bounce -> 4)
        add(0, 4'b0011, 1, 48, 6, 1, 1);
        add(1, 4'b0001, 1, 1,  0, 0, 1);
        add(0, 4'b0001, 1, 24, 3, 1, 1);
        add(0, 4'b0011, 1, 8,  4, 1, 1);
        // key: short glitch ignored, 10-cycle press pauses at edge 20, 100+ frozen, press resumes
        add(1, 4'b0001, 1, 1,  0, 0, 1);
        add(0, 4'b0001, 0, 3,  0, 0, 1);
        add(0, 4'b0001, 1, 10, 1, 0, 1);
        add(0, 4'b0001, 0, 6,  2, 0, 1);
        add(0, 4'b0001, 0, 1,  2, 0, 0);
        add(0, 4'b0001, 0, 3,  2, 0, 0);
        add(0, 4'b0001, 1, 110, 2, 0, 0);
        add(0, 4'b0001, 0, 6,  2, 0, 0);
        add(0, 4'b0001, 0, 1,  2, 0, 1);
        add(0, 4'b0001, 0, 3,  2, 0, 1);
        add(0, 4'b0001, 1, 1,  3, 1, 1);
        add(0, 4'b0001, 1, 16, 5, 1, 1);

        for (int i = 0; i < nv; i++) begin
            RST = tv[i].rst;
            SW  = tv[i].sw;
            KEY = tv[i].key;
            repeat (tv[i].n) @(posedge CLK);
            #1;
            chk("sel",  i, int'(SEL),  int'(tv[i].sel));
            chk("step", i, int'(STEP), int'(tv[i].step));
            chk("run",  i, int'(RUN),  int'(tv[i].run));
        end

        // step period: first STEP 8 edges after reset, then every 8
        RST = 1'b1; SW = 4'b0001; KEY = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(posedge CLK); #1;
                n++;
            end while (!STEP && n < 20);
            chk("step_period", k, n, 8);
        end

        // press-to-RUN latency
        RST = 1'b1; SW = 4'b0000; KEY = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; KEY = 1'b0;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (RUN && n < 20);
        chk("key_latency", 0, n, 7);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
